dart_throw_sequencer: RTL

//  Synthesizable, parametrised successor to the fixed dart stimulus source.

---
 rtl/dart_throw_sequencer.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/dart_throw_sequencer.sv
// Dart throw sequencer: paces dart_come/x/y strobes into the dart-game
// scoring core, rotating through players and stopping on game end,
// a win, or a player_done timeout.
module dart_throw_sequencer #(
  parameter int          COORD_W         = 8,
  parameter int          NUM_PLAYERS     = 2,
  parameter int          THROWS_PER_TURN = 3,
  parameter int          GAP_CYCLES      = 4,
  parameter int          TIMEOUT_CYCLES  = 1024,
  parameter int          SWEEP_STEP      = 1,
  parameter logic [31:0] LFSR_SEED       = 32'hACE1_0001
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start_i,
  input  logic [1:0]                     mode_i,
  input  logic [COORD_W-1:0]             fixed_x_i,
  input  logic [COORD_W-1:0]             fixed_y_i,
  input  logic                           game_set_i,
  input  logic [NUM_PLAYERS-1:0]         player_done_i,
  input  logic [NUM_PLAYERS-1:0]         player_win_i,
  output logic                           dart_come_o,
  output logic [COORD_W-1:0]             dart_position_x_o,
  output logic [COORD_W-1:0]             dart_position_y_o,
  output logic [$clog2(NUM_PLAYERS)-1:0] cur_player_o,
  output logic [15:0]                    throw_cnt_o,
  output logic                           busy_o,
  output logic                           finished_o,
  output logic                           winner_valid_o,
  output logic [$clog2(NUM_PLAYERS)-1:0] winner_o,
  output logic                           error_o
);

  localparam int PW     = $clog2(NUM_PLAYERS);
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TURN_W = $clog2(THROWS_PER_TURN + 1);

  // A GAP of 0 or 1 cycles both collapse to a single GAP cycle.
  localparam logic [GAP_W-1:0]   GAP_LAST    = GAP_W'((GAP_CYCLES > 1) ? GAP_CYCLES - 1 : 0);
  localparam logic [TO_W-1:0]    TO_LAST     = TO_W'((TIMEOUT_CYCLES > 1) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [TURN_W-1:0]  TURN_MAX    = TURN_W'(THROWS_PER_TURN);
  localparam logic [PW-1:0]      PLAYER_LAST = PW'(NUM_PLAYERS - 1);
  localparam logic [COORD_W-1:0] STEP_C      = COORD_W'(SWEEP_STEP);
  localparam logic [31:0]        LFSR_TAPS   = 32'h8020_0003;

  localparam logic [1:0] MODE_LFSR  = 2'd1;
  localparam logic [1:0] MODE_SWEEP = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_FIRE,
    S_WAIT_DONE,
    S_FINISH
  } state_t;

  state_t              state_q, state_d;
  logic [GAP_W-1:0]    gap_cnt_q;
  logic [TO_W-1:0]     wait_cnt_q;
  logic [TURN_W-1:0]   turn_cnt_q;
  logic [PW-1:0]       cur_player_q;
  logic [15:0]         throw_cnt_q;
  logic [COORD_W-1:0]  pos_x_q, pos_y_q;
  logic [COORD_W-1:0]  sweep_x_q, sweep_y_q;
  logic [COORD_W:0]    sweep_x_sum;
  logic [31:0]         lfsr_q, lfsr_next;
  logic                winner_valid_q;
  logic [PW-1:0]       winner_q;
  logic                error_q;

  logic                game_end;
  logic                busy;
  logic                done_cur;
  logic [PW-1:0]       win_idx;

  // FSM control strobes
  logic                start_game;
  logic                fire;
  logic                turn_adv;
  logic                timeout_hit;

  assign game_end    = game_set_i | (|player_win_i);
  assign busy        = (state_q == S_GAP) || (state_q == S_FIRE) || (state_q == S_WAIT_DONE);
  assign done_cur    = player_done_i[cur_player_q];
  assign lfsr_next   = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);
  assign sweep_x_sum = {1'b0, sweep_x_q} + {1'b0, STEP_C};

  // Lowest-index set win bit
  always_comb begin
    win_idx = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (player_win_i[i]) win_idx = PW'(i);
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; game end outranks every other transition
  always_comb begin
    state_d     = state_q;
    start_game  = 1'b0;
    fire        = 1'b0;
    turn_adv    = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      S_IDLE, S_FINISH: begin
        if (start_i) begin
          state_d    = S_GAP;
          start_game = 1'b1;
        end
      end
      S_GAP: begin
        if (game_end) begin
          state_d = S_FINISH;
        end else if (gap_cnt_q == GAP_LAST) begin
          state_d = S_FIRE;
          fire    = 1'b1;
        end
      end
      S_FIRE: begin
        if (game_end)                state_d = S_FINISH;
        else if (turn_cnt_q < TURN_MAX) state_d = S_GAP;
        else                         state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (game_end) begin
          state_d = S_FINISH;
        end else if (done_cur) begin
          state_d  = S_GAP;
          turn_adv = 1'b1;
        end else if (wait_cnt_q == TO_LAST) begin
          state_d     = S_FINISH;
          timeout_hit = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Gap and timeout timers restart whenever their state is (re)entered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap_cnt_q  <= '0;
      wait_cnt_q <= '0;
    end else begin
      gap_cnt_q  <= (state_q == S_GAP && state_d == S_GAP) ? gap_cnt_q + 1'b1 : '0;
      wait_cnt_q <= (state_q == S_WAIT_DONE && state_d == S_WAIT_DONE) ? wait_cnt_q + 1'b1 : '0;
    end
  end

  // Turn bookkeeping: throws in this turn, active player, game throw total
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      turn_cnt_q   <= '0;
      cur_player_q <= '0;
      throw_cnt_q  <= '0;
    end else if (start_game) begin
      turn_cnt_q   <= '0;
      cur_player_q <= '0;
      throw_cnt_q  <= '0;
    end else begin
      if (fire) begin
        turn_cnt_q <= turn_cnt_q + 1'b1;
        if (throw_cnt_q != 16'hFFFF) throw_cnt_q <= throw_cnt_q + 16'd1;
      end
      if (turn_adv) begin
        turn_cnt_q   <= '0;
        cur_player_q <= (cur_player_q == PLAYER_LAST) ? '0 : cur_player_q + 1'b1;
      end
    end
  end

  // Coordinate generation; x/y load on the edge that enters FIRE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_x_q   <= '0;
      pos_y_q   <= '0;
      sweep_x_q <= '0;
      sweep_y_q <= '0;
      lfsr_q    <= LFSR_SEED;
    end else if (start_game) begin
      sweep_x_q <= '0;
      sweep_y_q <= '0;
    end else if (fire) begin
      case (mode_i)
        MODE_LFSR: begin
          pos_x_q <= lfsr_next[COORD_W-1:0];
          pos_y_q <= lfsr_next[COORD_W+15:16];
          lfsr_q  <= lfsr_next;
        end
        MODE_SWEEP: begin
          pos_x_q   <= sweep_x_q;
          pos_y_q   <= sweep_y_q;
          sweep_x_q <= sweep_x_sum[COORD_W-1:0];
          if (sweep_x_sum[COORD_W]) sweep_y_q <= sweep_y_q + STEP_C;
        end
        default: begin
          pos_x_q <= fixed_x_i;
          pos_y_q <= fixed_y_i;
        end
      endcase
    end
  end

  // Winner capture (first win only) and sticky timeout flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      winner_valid_q <= 1'b0;
      winner_q       <= '0;
      error_q        <= 1'b0;
    end else if (start_game) begin
      winner_valid_q <= 1'b0;
      winner_q       <= '0;
      error_q        <= 1'b0;
    end else begin
      if (busy && (|player_win_i) && !winner_valid_q) begin
        winner_valid_q <= 1'b1;
        winner_q       <= win_idx;
      end
      if (timeout_hit) error_q <= 1'b1;
    end
  end

  assign dart_come_o       = (state_q == S_FIRE);
  assign dart_position_x_o = pos_x_q;
  assign dart_position_y_o = pos_y_q;
  assign cur_player_o      = cur_player_q;
  assign throw_cnt_o       = throw_cnt_q;
  assign busy_o            = busy;
  assign finished_o        = (state_q == S_FINISH);
  assign winner_valid_o    = winner_valid_q;
  assign winner_o          = winner_q;
  assign error_o           = error_q;

endmodule
